// File: rtl/sync_pla_pkg.sv
// Shared constants for the synchronous PLA engine: plane selects and programming-address width.
// The address width grows by one row when PLA_OUT_INV_EN adds the output-inversion register.
package sync_pla_pkg;

    localparam logic PLANE_AND = 1'b0;
    localparam logic PLANE_OR  = 1'b1;

    function automatic int pla_addr_w(input int n_terms, input int n_out);
        int rows;
        rows = (n_terms > n_out) ? n_terms : n_out;
`ifdef PLA_OUT_INV_EN
        // The inversion register lives at OR address n_out, so it must be addressable.
        if (n_out + 1 > rows) rows = n_out + 1;
`endif
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/pla_and_row.sv
// One AND-plane row: loadable care mask and compare value, plus the combinational match.
module pla_and_row #(
    parameter int N_IN = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [N_IN-1:0] care_in,
    input  logic [N_IN-1:0] val_in,
    input  logic [N_IN-1:0] data,
    output logic            hit
);

    logic [N_IN-1:0] care_q, care_d;
    logic [N_IN-1:0] val_q,  val_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        care_d = care_q;
        val_d  = val_q;
        if (we) begin
            care_d = care_in;
            val_d  = val_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
    always_ff @(posedge clk) begin
        if (rst) begin
            care_q <= '0;
            val_q  <= '0;
        end else begin
            care_q <= care_d;
            val_q  <= val_d;
        end
    end

    // Unmasked bits must equal the compare value; a fully masked row always matches.
    assign hit = &(~care_q | ~(data ^ val_q));

endmodule

// File: rtl/sync_pla_engine.sv
// Run-time programmable PLA with a 2-stage valid/ready pipeline (AND terms, then OR plane).
// Optional macro PLA_OUT_INV_EN adds a per-output inversion register at OR address N_OUT.
module sync_pla_engine
    import sync_pla_pkg::*;
#(
    parameter  int N_IN    = 7,
    parameter  int N_TERMS = 8,
    parameter  int N_OUT   = 3,
    localparam int ADDR_W  = pla_addr_w(N_TERMS, N_OUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic               prog_plane,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [N_IN-1:0]    prog_care,
    input  logic [N_IN-1:0]    prog_val,
    input  logic [N_TERMS-1:0] prog_or,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_OUT-1:0]   out_data,
    output logic [N_TERMS-1:0] term_hit
);

    logic [N_TERMS-1:0] term_vec;

    for (genvar t = 0; t < N_TERMS; t++) begin : g_and_row
        pla_and_row #(.N_IN(N_IN)) u_row (
            .clk     (clk),
            .rst     (rst),
            .we      (prog_we && (prog_plane == PLANE_AND) && (prog_addr == ADDR_W'(t))),
            .care_in (prog_care),
            .val_in  (prog_val),
            .data    (in_data),
            .hit     (term_vec[t])
        );
    end

    logic [N_OUT-1:0][N_TERMS-1:0] or_mask_q, or_mask_d;
    logic [N_OUT-1:0]              inv_q;
    logic [N_OUT-1:0]              or_result;

    // Addresses that match no row fall through untouched, which ignores out-of-range writes.
    always_comb begin
        or_mask_d = or_mask_q;
        if (prog_we && (prog_plane == PLANE_OR)) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (prog_addr == ADDR_W'(j)) or_mask_d[j] = prog_or;
            end
        end
    end

`ifdef PLA_OUT_INV_EN
    logic [N_OUT-1:0] inv_d;

    always_comb begin
        inv_d = inv_q;
        if (prog_we && (prog_plane == PLANE_OR) && (prog_addr == ADDR_W'(N_OUT)))
            inv_d = prog_or[N_OUT-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) inv_q <= '0;
        else     inv_q <= inv_d;
    end
`else
    assign inv_q = '0;
`endif

    // NOTE: the personality storage is reset because unprogrammed rows must read as empty.
    always_ff @(posedge clk) begin
        if (rst) or_mask_q <= '0;
        else     or_mask_q <= or_mask_d;
    end

    logic               v1_q, v1_d;
    logic [N_TERMS-1:0] term1_q, term1_d;
    logic               v2_q, v2_d;
    logic [N_OUT-1:0]   out2_q, out2_d;
    logic [N_TERMS-1:0] hit2_q, hit2_d;
    logic               stage2_adv;

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            or_result[j] = (|(term1_q & or_mask_q[j])) ^ inv_q[j];
        end
    end

    // Both stages depend only on registered state and out_ready, never on in_valid.
    always_comb begin
        stage2_adv = !v2_q || out_ready;
        in_ready   = !v1_q || stage2_adv;

        v1_d    = v1_q;
        term1_d = term1_q;
        if (in_ready) begin
            v1_d = in_valid;
            if (in_valid) term1_d = term_vec;
        end

        v2_d   = v2_q;
        out2_d = out2_q;
        hit2_d = hit2_q;
        if (stage2_adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                out2_d = or_result;
                hit2_d = term1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            term1_q <= '0;
            v2_q    <= 1'b0;
            out2_q  <= '0;
            hit2_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            term1_q <= term1_d;
            v2_q    <= v2_d;
            out2_q  <= out2_d;
            hit2_q  <= hit2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = out2_q;
    assign term_hit  = hit2_q;

endmodule

// File: tb/tb_sync_pla_engine.sv
// Self-checking bench for sync_pla_engine (N_IN=3, N_TERMS=4, N_OUT=4): directed scenarios, then random traffic.
// The inversion scenario runs only when PLA_OUT_INV_EN is defined.
module tb_sync_pla_engine;

    localparam int AW = sync_pla_pkg::pla_addr_w(4, 4);

    logic          clk;
    logic          rst;
    logic          prog_we;
    logic          prog_plane;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_care;
    logic [2:0]    prog_val;
    logic [3:0]    prog_or;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_data;
    logic [3:0]    term_hit;

    sync_pla_engine #(.N_IN(3), .N_TERMS(4), .N_OUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_plane (prog_plane),
        .prog_addr  (prog_addr),
        .prog_care  (prog_care),
        .prog_val   (prog_val),
        .prog_or    (prog_or),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .term_hit   (term_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: personality tables plus an in-order queue of accepted items.
    logic [2:0] m_care[4];
    logic [2:0] m_val[4];
    logic [3:0] m_or[4];
    logic [3:0] m_inv;

    typedef struct {
        logic [3:0] terms;
        logic [3:0] outv;
        bit         shown;
    } ent_t;
    ent_t q[$];

    logic [3:0] seen[$];
    logic [3:0] seen_hit[$];
    int         dut_acc;

    function automatic logic [3:0] model_terms(input logic [2:0] d);
        logic [3:0] r;
        for (int t = 0; t < 4; t++) begin
            r[t] = 1'b1;
            for (int b = 0; b < 3; b++) begin
                if (m_care[t][b] && (d[b] != m_val[t][b])) r[t] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] model_out(input logic [3:0] terms);
        logic [3:0] o;
        for (int j = 0; j < 4; j++) begin
            o[j] = 1'b0;
            for (int t = 0; t < 4; t++) begin
                if (terms[t] && m_or[j][t]) o[j] = 1'b1;
            end
            o[j] = o[j] ^ m_inv[j];
        end
        return o;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < 4; t++) begin
            m_care[t] = '0;
            m_val[t]  = '0;
            m_or[t]   = '0;
        end
        m_inv = '0;
        q.delete();
    endtask

    // One clock cycle: drive at the falling edge, check outputs, then advance the model at the rising edge.
    task automatic cycle(input bit r, input bit iv, input logic [2:0] din, input bit ordy,
                         input bit we, input bit plane, input int addr,
                         input logic [2:0] care_v, input logic [2:0] val_v, input logic [3:0] orv);
        bit   exp_in_ready, exp_valid, in_fire, out_fire;
        ent_t e;
        rst        = r;
        in_valid   = iv;
        in_data    = din;
        out_ready  = ordy;
        prog_we    = we;
        prog_plane = plane;
        prog_addr  = AW'(addr);
        prog_care  = care_v;
        prog_val   = val_v;
        prog_or    = orv;
        #1;
        exp_in_ready = (q.size() < 2) || ordy;
        exp_valid    = (q.size() > 0) && q[0].shown;
        check("in_ready", 32'(in_ready), 32'(exp_in_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_data", 32'(out_data), 32'(q[0].outv));
            check("term_hit", 32'(term_hit), 32'(q[0].terms));
        end
        in_fire  = iv && exp_in_ready;
        out_fire = exp_valid && ordy;
        if (iv && in_ready) dut_acc++;
        if (out_valid && out_ready) begin
            seen.push_back(out_data);
            seen_hit.push_back(term_hit);
        end
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            if (out_fire) void'(q.pop_front());
            // The head crosses into the output stage here, using the OR plane as it was before this edge.
            if (q.size() > 0 && !q[0].shown) begin
                e       = q[0];
                e.shown = 1'b1;
                e.outv  = model_out(e.terms);
                q[0]    = e;
            end
            if (in_fire) begin
                e.terms = model_terms(din);
                e.outv  = '0;
                e.shown = 1'b0;
                q.push_back(e);
            end
            if (we) begin
                if (!plane && addr < 4) begin
                    m_care[addr] = care_v;
                    m_val[addr]  = val_v;
                end else if (plane && addr < 4) begin
                    m_or[addr] = orv;
                end
`ifdef PLA_OUT_INV_EN
                else if (plane && addr == 4) begin
                    m_inv = orv;
                end
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(0, 0, 3'b000, ordy, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic push(input logic [2:0] din, input bit ordy);
        cycle(0, 1, din, ordy, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic prog_and(input int t, input logic [2:0] care_v, input logic [2:0] val_v);
        cycle(0, 0, 3'b000, 1, 1, sync_pla_pkg::PLANE_AND, t, care_v, val_v, '0);
    endtask

    task automatic prog_orw(input int j, input logic [3:0] mask);
        cycle(0, 0, 3'b000, 1, 1, sync_pla_pkg::PLANE_OR, j, '0, '0, mask);
    endtask

    task automatic load_test_rows();
        prog_and(0, 3'b110, 3'b100);   // 10?
        prog_and(1, 3'b001, 3'b001);   // ??1
        prog_and(2, 3'b101, 3'b000);   // 0?0
        prog_and(3, 3'b000, 3'b000);   // ???
        for (int j = 0; j < 4; j++) prog_orw(j, 4'(1 << j));
    endtask

    initial begin
        rst = 1'b1; prog_we = 0; prog_plane = 0; prog_addr = '0; prog_care = '0;
        prog_val = '0; prog_or = '0; in_valid = 0; in_data = '0; out_ready = 1;
        dut_acc = 0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_term_hit", 32'(term_hit), 32'd0);

        // Unprogrammed personality: every term matches but no output selects any term.
        seen.delete(); seen_hit.delete();
        push(3'b111, 1);
        idle(3, 1);
        check("unprog_count", 32'(seen.size()), 32'd1);
        if (seen.size() >= 1) check("unprog_out", 32'(seen[0]), 32'h0);

        // Back-to-back evaluation with the test personality.
        load_test_rows();
        seen.delete(); seen_hit.delete();
        push(3'b111, 1);
        push(3'b000, 1);
        push(3'b101, 1);
        idle(3, 1);
        check("b2b_count", 32'(seen.size()), 32'd3);
        if (seen.size() >= 3) begin
            check("b2b_out0", 32'(seen[0]), 32'hA);
            check("b2b_out1", 32'(seen[1]), 32'hC);
            check("b2b_out2", 32'(seen[2]), 32'hB);
            for (int i = 0; i < 3; i++) check("b2b_hit_eq_out", 32'(seen_hit[i]), 32'(seen[i]));
        end

        // Backpressure: only two results fit, and they drain in order once released.
        seen.delete(); seen_hit.delete();
        dut_acc = 0;
        push(3'b111, 0);
        push(3'b000, 0);
        push(3'b101, 0);
        push(3'b101, 0);
        check("stall_accepts", 32'(dut_acc), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_held_out", 32'(out_data), 32'hA);
        push(3'b101, 1);
        idle(4, 1);
        check("drain_count", 32'(seen.size()), 32'd3);
        if (seen.size() >= 3) begin
            check("drain_out0", 32'(seen[0]), 32'hA);
            check("drain_out1", 32'(seen[1]), 32'hC);
            check("drain_out2", 32'(seen[2]), 32'hB);
        end

        // AND write in the accepting cycle is not seen by that input, only by the next one.
        seen.delete(); seen_hit.delete();
        cycle(0, 1, 3'b011, 1, 1, sync_pla_pkg::PLANE_AND, 0, 3'b000, 3'b000, '0);
        push(3'b011, 1);
        idle(3, 1);
        check("wr_race_count", 32'(seen.size()), 32'd2);
        if (seen.size() >= 2) begin
            check("wr_race_old_row", 32'(seen[0][0]), 32'd0);
            check("wr_race_new_row", 32'(seen[1][0]), 32'd1);
        end

        // Reset with two results in flight discards them.
        seen.delete(); seen_hit.delete();
        push(3'b111, 0);
        push(3'b000, 0);
        cycle(1, 0, 3'b000, 0, 0, 0, 0, '0, '0, '0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_data", 32'(out_data), 32'd0);
        check("flush_term_hit", 32'(term_hit), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        idle(4, 1);
        check("flush_no_output", 32'(seen.size()), 32'd0);

`ifdef PLA_OUT_INV_EN
        load_test_rows();
        prog_orw(4, 4'b0001);
        seen.delete(); seen_hit.delete();
        push(3'b111, 1);
        idle(3, 1);
        check("inv_count", 32'(seen.size()), 32'd1);
        if (seen.size() >= 1) check("inv_out", 32'(seen[0]), 32'hB);
`endif

        // Random personality, traffic, backpressure and live reprogramming.
        for (int t = 0; t < 4; t++) prog_and(t, 3'($urandom), 3'($urandom));
        for (int j = 0; j < 4; j++) prog_orw(j, 4'($urandom));
        for (int i = 0; i < 400; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), 3'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), 1'($urandom), int'($urandom_range(0, (1 << AW) - 1)),
                  3'($urandom), 3'($urandom), 4'($urandom));
        end
        idle(6, 1);
        check("final_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
